// File: rtl/hog_svm_pkg.sv
// Shared constants and state encoding for the SVM coefficient loader.
package hog_svm_pkg;

   localparam int BUS_W   = 32;
   localparam int COEF_W  = 12;
   localparam int N_COEF  = 105;
   localparam int N_WORD  = 36;
   localparam int ADDR_W  = 6;
   localparam int RAM_DW  = COEF_W * N_COEF;
   localparam int BEATS   = (RAM_DW + BUS_W - 1) / BUS_W;
   localparam int BEAT_CW = $clog2(BEATS);
   localparam int BUF_W   = BEATS * BUS_W;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      WRITE,
      RDBK,
      CMP,
      BIAS,
      DONE,
      ERR
   } loader_state_t;

endpackage

// File: rtl/coef_word_packer.sv
// Assembles narrow stream beats into one wide coefficient-RAM word, LSB beat first.
// The tail of the last beat beyond the RAM word width is dropped.
module coef_word_packer
   import hog_svm_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               beat_en,
   input  logic [BUS_W-1:0]   beat_data,
   output logic [RAM_DW-1:0]  word,
   output logic [BEAT_CW-1:0] beat_cnt,
   output logic               word_done
);

   logic [BUF_W-1:0] buffer;
   logic             unused_tail;

   assign word_done   = beat_en && (beat_cnt == BEAT_CW'(BEATS - 1));
   assign word        = buffer[RAM_DW-1:0];
   assign unused_tail = ^buffer[BUF_W-1:RAM_DW];

   // Beat counter: wraps to zero on the last beat of a word, restarts on a new load
   always_ff @(posedge clk) begin
      if (!rst) begin
         beat_cnt <= '0;
      end else if (clear) begin
         beat_cnt <= '0;
      end else if (beat_en) begin
         beat_cnt <= word_done ? '0 : beat_cnt + BEAT_CW'(1);
      end
   end

   // Word buffer: each accepted beat lands in the slot selected by the beat counter
   always_ff @(posedge clk) begin
      if (!rst) begin
         buffer <= '0;
      end else if (beat_en) begin
         for (int k = 0; k < BEATS; k++) begin
            if (beat_cnt == k[BEAT_CW-1:0]) begin
               buffer[k*BUS_W +: BUS_W] <= beat_data;
            end
         end
      end
   end

endmodule

// File: rtl/svm_coef_loader.sv
// Boot-time loader for the SVM model: packs streamed coefficients into RAM words,
// loads the bias, and keeps the pixel-fetch handshake closed until the model is complete.
// Optional build macro SVM_COEF_VERIFY_EN adds a read-back check of every written word.
module svm_coef_loader
   import hog_svm_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [BUS_W-1:0]  s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [ADDR_W-1:0] addr_a,
   output logic              write_en,
   output logic [RAM_DW-1:0] i_data_a,
   input  logic [RAM_DW-1:0] o_data_a,
   output logic [COEF_W-1:0] bias,
   output logic              b_load,
   input  logic              fetch_rdy_i,
   output logic              fetch_rdy_o,
   output logic              run_en,
   output logic              busy,
   output logic              err
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORD - 1);

   loader_state_t      state;
   loader_state_t      state_next;
   logic               start_ok;
   logic               pack_en;
   logic               word_done;
   logic               word_ok;
   logic               bias_pending;
   logic [BEAT_CW-1:0] beat_cnt;

   assign start_ok    = start && ((state == IDLE) || (state == DONE) || (state == ERR));
   assign pack_en     = s_valid && s_ready && (state == FILL);
   assign fetch_rdy_o = fetch_rdy_i & run_en;

`ifdef SVM_COEF_VERIFY_EN
   logic mismatch;
   logic err_q;
   assign mismatch = (o_data_a != i_data_a);
   assign word_ok  = (state == CMP) && !mismatch;
   assign err      = err_q;
`else
   logic unused_rd;
   assign unused_rd = ^o_data_a;
   assign word_ok   = (state == WRITE);
   assign err       = 1'b0;
`endif

   coef_word_packer u_packer (
      .clk       (clk),
      .rst       (rst),
      .clear     (start_ok),
      .beat_en   (pack_en),
      .beat_data (s_data),
      .word      (i_data_a),
      .beat_cnt  (beat_cnt),
      .word_done (word_done)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and per-state strobes; the bias slot closes its ready while b_load is shown
   always_comb begin
      state_next = state;
      s_ready    = 1'b0;
      write_en   = 1'b0;
      b_load     = 1'b0;
      busy       = 1'b0;
      run_en     = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = FILL;
         end
         FILL: begin
            s_ready = 1'b1;
            busy    = 1'b1;
            if (word_done) state_next = WRITE;
         end
         WRITE: begin
            write_en = 1'b1;
            busy     = 1'b1;
`ifdef SVM_COEF_VERIFY_EN
            state_next = RDBK;
`else
            state_next = (addr_a == LAST_ADDR) ? BIAS : FILL;
`endif
         end
`ifdef SVM_COEF_VERIFY_EN
         RDBK: begin
            busy       = 1'b1;
            state_next = CMP;
         end
         CMP: begin
            busy = 1'b1;
            if (mismatch)                state_next = ERR;
            else if (addr_a == LAST_ADDR) state_next = BIAS;
            else                          state_next = FILL;
         end
`endif
         BIAS: begin
            busy    = 1'b1;
            s_ready = !bias_pending;
            b_load  = bias_pending;
            if (bias_pending) state_next = DONE;
         end
         DONE: begin
            run_en = 1'b1;
            if (start) state_next = FILL;
         end
         ERR: begin
            if (start) state_next = FILL;
         end
         default: state_next = IDLE;
      endcase
   end

   // Word address: restarts on a new load, advances after each word is committed
   always_ff @(posedge clk) begin
      if (!rst) begin
         addr_a <= '0;
      end else if (start_ok) begin
         addr_a <= '0;
      end else if (word_ok && (addr_a != LAST_ADDR)) begin
         addr_a <= addr_a + ADDR_W'(1);
      end
   end

   // Bias capture; the pending flag produces the single-cycle b_load after the accept
   always_ff @(posedge clk) begin
      if (!rst) begin
         bias         <= '0;
         bias_pending <= 1'b0;
      end else begin
         bias_pending <= (state == BIAS) && !bias_pending && s_valid;
         if ((state == BIAS) && !bias_pending && s_valid) begin
            bias <= s_data[COEF_W-1:0];
         end
      end
   end

`ifdef SVM_COEF_VERIFY_EN
   // Sticky read-back error, cleared only by a new load
   always_ff @(posedge clk) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else if (start_ok) begin
         err_q <= 1'b0;
      end else if ((state == CMP) && mismatch) begin
         err_q <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_svm_coef_loader.sv
// Self-checking bench for svm_coef_loader: streams randomized models and compares the
// RAM writes and bias load against a reference built directly from the stream contents.
module tb_svm_coef_loader;
   import hog_svm_pkg::*;

   localparam int TOTAL = N_WORD * BEATS + 1;

   logic              clk;
   logic              rst;
   logic              start;
   logic [BUS_W-1:0]  s_data;
   logic              s_valid;
   logic              s_ready;
   logic [ADDR_W-1:0] addr_a;
   logic              write_en;
   logic [RAM_DW-1:0] i_data_a;
   logic [RAM_DW-1:0] o_data_a;
   logic [COEF_W-1:0] bias;
   logic              b_load;
   logic              fetch_rdy_i;
   logic              fetch_rdy_o;
   logic              run_en;
   logic              busy;
   logic              err;

   int total;
   int bad;

   logic [BUS_W-1:0]  beats [0:N_WORD*BEATS-1];
   logic [BUS_W-1:0]  bias_beat;
   logic [RAM_DW-1:0] ram [0:N_WORD-1];
   bit                corrupt;

   int                wr_addr_q[$];
   logic [RAM_DW-1:0] wr_data_q[$];
   int                bload_cnt;
   logic [COEF_W-1:0] bias_at_load;
   bit                bload_seen;
   int                viol;

   svm_coef_loader dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .addr_a      (addr_a),
      .write_en    (write_en),
      .i_data_a    (i_data_a),
      .o_data_a    (o_data_a),
      .bias        (bias),
      .b_load      (b_load),
      .fetch_rdy_i (fetch_rdy_i),
      .fetch_rdy_o (fetch_rdy_o),
      .run_en      (run_en),
      .busy        (busy),
      .err         (err)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model with one-cycle read latency and an optional stuck bit on word 5
   always @(posedge clk) begin
      if (write_en === 1'b1) begin
         if (corrupt && addr_a == 6'd5) ram[addr_a] <= i_data_a ^ {{(RAM_DW-1){1'b0}}, 1'b1};
         else                          ram[addr_a] <= i_data_a;
      end
      o_data_a <= ram[addr_a];
   end

   // Observer: logs RAM writes and bias loads, and tallies protocol-invariant violations
   always @(negedge clk) begin
      if (write_en === 1'b1) begin
         wr_addr_q.push_back(int'(addr_a));
         wr_data_q.push_back(i_data_a);
      end
      if (b_load === 1'b1) begin
         bload_cnt++;
         bias_at_load = bias;
      end
      if (write_en === 1'b1 && b_load === 1'b1) viol++;
      if (write_en === 1'b1 && s_ready === 1'b1) viol++;
      if (int'(addr_a) > N_WORD - 1) viol++;
      if (fetch_rdy_o === 1'b1 && !bload_seen) viol++;
      if (b_load === 1'b1) bload_seen = 1'b1;
   end

   task automatic check_output(input string tag, input logic [RAM_DW-1:0] obs,
                               input logic [RAM_DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [RAM_DW-1:0] exp_word(input int w);
      logic [BUF_W-1:0] v;
      v = '0;
      for (int k = 0; k < BEATS; k++) v[k*BUS_W +: BUS_W] = beats[w*BEATS + k];
      return v[RAM_DW-1:0];
   endfunction

   task automatic gen_beats(input bit rnd);
      logic [7:0] wb;
      logic [7:0] kb;
      for (int w = 0; w < N_WORD; w++) begin
         for (int k = 0; k < BEATS; k++) begin
            wb = w[7:0];
            kb = k[7:0];
            beats[w*BEATS + k] = rnd ? $urandom : {wb, kb, 16'hA5C3};
         end
      end
      bias_beat = rnd ? $urandom : 32'h0000_0ABC;
   endtask

   task automatic do_start();
      @(negedge clk); #1;
      start = 1'b1;
      wr_addr_q.delete();
      wr_data_q.delete();
      bload_cnt  = 0;
      bload_seen = 1'b0;
      viol       = 0;
      @(negedge clk); #1;
      start = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_output({tag, "_s_ready"},  s_ready,  0);
      check_output({tag, "_write_en"}, write_en, 0);
      check_output({tag, "_b_load"},   b_load,   0);
      check_output({tag, "_run_en"},   run_en,   0);
      check_output({tag, "_busy"},     busy,     0);
      check_output({tag, "_err"},      err,      0);
      check_output({tag, "_addr_a"},   addr_a,   0);
      check_output({tag, "_i_data_a"}, i_data_a, 0);
      check_output({tag, "_bias"},     bias,     0);
   endtask

   // Streams the model; stops early after stop_words writes or on err, and pulses start
   // while ready is high at the two given beat indices
   task automatic apply_stimulus(input int pct, input int stop_words,
                                 input int start_idx0, input int start_idx1);
      int idx;
      int cycles;
      bit stopped;
      bit fired0;
      bit fired1;
      idx = 0; cycles = 0; stopped = 0; fired0 = 0; fired1 = 0;
      while (idx < TOTAL && cycles < 20000 && !stopped) begin
         @(negedge clk); #1;
         start = 1'b0;
         if ((stop_words > 0 && wr_addr_q.size() >= stop_words) || err === 1'b1) begin
            stopped = 1'b1;
            s_valid = 1'b0;
         end else begin
            s_valid = ($urandom_range(0, 99) < pct);
            s_data  = (idx < N_WORD*BEATS) ? beats[idx] : bias_beat;
            if (s_ready === 1'b1 && idx == start_idx0 && !fired0) begin start = 1'b1; fired0 = 1; end
            if (s_ready === 1'b1 && idx == start_idx1 && !fired1) begin start = 1'b1; fired1 = 1; end
            if (s_valid && s_ready === 1'b1) idx++;
         end
         cycles++;
      end
      @(negedge clk); #1;
      s_valid = 1'b0;
      start   = 1'b0;
      if (!stopped) check_output("stream_complete", idx, TOTAL);
   endtask

   task automatic wait_run_en(input string tag);
      int n;
      n = 0;
      while (run_en !== 1'b1 && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      check_output({tag, "_run_en_up"}, run_en, 1);
      check_output({tag, "_busy_done"}, busy, 0);
   endtask

   task automatic check_load(input string tag);
      check_output({tag, "_write_count"}, wr_addr_q.size(), N_WORD);
      for (int i = 0; i < N_WORD; i++) begin
         if (i < wr_addr_q.size()) begin
            check_output($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], i);
            check_output($sformatf("%s_data%0d", tag, i), wr_data_q[i], exp_word(i));
         end
      end
      check_output({tag, "_bload_count"}, bload_cnt, 1);
      check_output({tag, "_bias"}, bias_at_load, bias_beat[COEF_W-1:0]);
      check_output({tag, "_invariants"}, viol, 0);
   endtask

   // Directed sequence of loads, resets and start pulses
   initial begin
      total = 0; bad = 0; viol = 0; bload_cnt = 0; bload_seen = 1'b0; corrupt = 1'b0;
      rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; fetch_rdy_i = 1'b1;
      bias_at_load = '0;
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("por");
      check_output("por_fetch_rdy_o", fetch_rdy_o, 0);
      rst = 1'b1;

      $display("[TB] full-rate load with pattern beats");
      gen_beats(1'b0);
      do_start();
      check_output("t1_busy_started", busy, 1);
      apply_stimulus(100, 0, -1, -1);
      wait_run_en("t1");
      check_load("t1");
      check_output("t1_fetch_open", fetch_rdy_o, 1);
      fetch_rdy_i = 1'b0; #1;
      check_output("t1_fetch_gated_by_input", fetch_rdy_o, 0);
      fetch_rdy_i = 1'b1; #1;

      $display("[TB] restart from DONE, random data, 50%% valid");
      gen_beats(1'b1);
      do_start();
      check_output("t2_run_en_drop", run_en, 0);
      check_output("t2_fetch_closed", fetch_rdy_o, 0);
      apply_stimulus(50, 0, -1, -1);
      wait_run_en("t2");
      check_load("t2");

      $display("[TB] reset in the middle of a load");
      gen_beats(1'b1);
      do_start();
      apply_stimulus(70, 18, -1, -1);
      check_output("t4_writes_before_reset", wr_addr_q.size(), 18);
      check_output("t4_last_addr_before_reset", wr_addr_q[wr_addr_q.size()-1], 17);
      @(negedge clk); #1;
      rst = 1'b0;
      bload_seen = 1'b0;
      @(negedge clk); #1;
      check_reset_outputs("t4_rst");
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check_output("t4_idle_run_en", run_en, 0);
      do_start();
      apply_stimulus(100, 0, -1, -1);
      wait_run_en("t4");
      check_load("t4");

      $display("[TB] stray start pulses during FILL and BIAS");
      gen_beats(1'b1);
      do_start();
      apply_stimulus(80, 0, 100, N_WORD*BEATS);
      wait_run_en("t5");
      check_load("t5");

`ifdef SVM_COEF_VERIFY_EN
      $display("[TB] read-back error on word 5");
      gen_beats(1'b1);
      corrupt = 1'b1;
      do_start();
      apply_stimulus(100, 0, -1, -1);
      repeat (5) @(negedge clk);
      #1;
      check_output("t6_err", err, 1);
      check_output("t6_run_en", run_en, 0);
      check_output("t6_busy", busy, 0);
      check_output("t6_addr_held", addr_a, 5);
      check_output("t6_write_count", wr_addr_q.size(), 6);
      check_output("t6_last_write", wr_addr_q[wr_addr_q.size()-1], 5);
      check_output("t6_no_bias", bload_cnt, 0);
      corrupt = 1'b0;
      do_start();
      check_output("t6_err_cleared", err, 0);
      apply_stimulus(100, 0, -1, -1);
      wait_run_en("t6");
      check_load("t6");
`else
      check_output("err_tied_low", err, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
